// File: rtl/booth_r4_seq_mac.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_seq_mac
// Brief    : Sequential radix-4 Booth multiply-accumulate, one digit per clock.
// Revision : 1.0
// ============================================================================
module booth_r4_seq_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 acc_mode_i,
  input  logic                 acc_clr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] result_o,
  output logic                 ovf_o
);

  localparam int PW    = 2*WIDTH;
  localparam int MW    = WIDTH+2;
  localparam int CNT_W = $clog2(WIDTH/2+1);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH/2);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CALC = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [MW-1:0]        mplr_q, mplr_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 clr_q, clr_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;

  logic [MW-1:0]        m_ext;
  logic [MW-1:0]        pp;
  logic [PW-1:0]        pp_ext;
  logic [PW-1:0]        pp_shift;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf_hit;

  // Two guard bits let +/-2M cover the most negative multiplicand.
  assign m_ext = {{2{a_q[WIDTH-1]}}, a_q};

  always_comb begin
    pp = '0;
    case (mplr_q[2:0])
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
  end

  assign pp_ext   = {{(PW-MW){pp[MW-1]}}, pp};
  assign pp_shift = pp_ext << {cnt_q, 1'b0};

  generate
    if (ACC_WIDTH > PW) begin : g_sext
      assign p_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    end else begin : g_noext
      assign p_ext = prod_q;
    end
  endgenerate

  assign base    = clr_q ? '0 : acc_q;
  assign sum     = base + p_ext;
  assign ovf_hit = (base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    mplr_d   = mplr_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    clr_d    = clr_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      C_IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          mplr_d  = {b_i[WIDTH-1], b_i, 1'b0};
          mode_d  = acc_mode_i;
          clr_d   = acc_clr_i;
          prod_d  = '0;
          cnt_d   = '0;
          state_d = C_CALC;
        end
      end
      C_CALC: begin
        // Counter reaching WIDTH/2 marks the finalisation cycle after the last digit.
        if (cnt_q == C_LAST) begin
          state_d = C_DONE;
          if (mode_q) begin
            result_d = sum;
            acc_d    = sum;
            ovf_d    = (ovf_q & ~clr_q) | ovf_hit;
          end else begin
            result_d = p_ext;
          end
        end else begin
          prod_d = prod_q + pp_shift;
          mplr_d = {{2{mplr_q[MW-1]}}, mplr_q[MW-1:2]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      C_DONE: begin
        if (out_ready_i) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= C_IDLE;
      a_q      <= '0;
      mplr_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      clr_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      mplr_q   <= mplr_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      clr_q    <= clr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == C_IDLE);
  assign out_valid_o = (state_q == C_DONE);
  assign result_o    = result_q;
  assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_r4_seq_mac
// Brief    : Directed and model-checked bench for booth_r4_seq_mac.
// Revision : 1.0
// ============================================================================
module tb_booth_r4_seq_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  iv;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  fl;
  logic        ordy;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic        mode;
  logic        clr;
  logic [19:0] r0;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [35:0] r3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // 0: W8/A20, 1: W8/A16, 2: W6/A16, 3: W16/A36
  booth_r4_seq_mac #(.WIDTH(8), .ACC_WIDTH(20)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .a_i(a_bus[7:0]), .b_i(b_bus[7:0]), .acc_mode_i(mode), .acc_clr_i(clr),
    .out_valid_o(ov[0]), .out_ready_i(ordy), .result_o(r0), .ovf_o(fl[0]));

  booth_r4_seq_mac #(.WIDTH(8), .ACC_WIDTH(16)) u_w8a16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .a_i(a_bus[7:0]), .b_i(b_bus[7:0]), .acc_mode_i(mode), .acc_clr_i(clr),
    .out_valid_o(ov[1]), .out_ready_i(ordy), .result_o(r1), .ovf_o(fl[1]));

  booth_r4_seq_mac #(.WIDTH(6)) u_w6 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .a_i(a_bus[5:0]), .b_i(b_bus[5:0]), .acc_mode_i(mode), .acc_clr_i(clr),
    .out_valid_o(ov[2]), .out_ready_i(ordy), .result_o(r2), .ovf_o(fl[2]));

  booth_r4_seq_mac #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv[3]), .in_ready_o(ir[3]),
    .a_i(a_bus), .b_i(b_bus), .acc_mode_i(mode), .acc_clr_i(clr),
    .out_valid_o(ov[3]), .out_ready_i(ordy), .result_o(r3), .ovf_o(fl[3]));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint pick(input int sel);
    case (sel)
      0:       return longint'($signed(r0));
      1:       return longint'($signed(r1));
      2:       return longint'($signed(r2));
      default: return longint'($signed(r3));
    endcase
  endfunction

  function automatic int half(input int sel);
    case (sel)
      2:       return 3;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic longint wrap(input longint v, input int w);
    logic [63:0] t;
    t = v;
    t = t << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

  // Presents one beat, waits for acceptance and for the result; checks latency.
  task automatic beat(input int sel, input int av, input int bv, input logic m,
                      input logic c, output longint r, output logic f);
    int n;
    int lat;
    a_bus   = 16'(av);
    b_bus   = 16'(bv);
    mode    = m;
    clr     = c;
    iv[sel] = 1'b1;
    n = 0;
    while (ir[sel] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", n, 0);
    @(posedge clk); #1;
    iv[sel] = 1'b0;
    lat = 0;
    while (ov[sel] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, half(sel) + 1);
    r = pick(sel);
    f = fl[sel];
  endtask

  initial begin
    longint r;
    logic   f;
    longint acc_m;
    logic   ovf_m;
    longint p;
    longint bs;
    longint s;
    longint exp;
    logic signed [15:0] t16a;
    logic signed [15:0] t16b;
    logic   m;
    logic   c;
    int     k;

    iv = '0; a_bus = '0; b_bus = '0; mode = 1'b0; clr = 1'b0; ordy = 1'b1;

    #3;
    check("rst_in_ready",  ir[0], 1);
    check("rst_out_valid", ov[0], 0);
    check("rst_result",    pick(0), 0);
    check("rst_ovf",       fl[0], 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    beat(0, 7, -3, 1'b0, 1'b0, r, f);     check("mul_7x-3", r, -21);
    beat(0, -128, -128, 1'b0, 1'b0, r, f); check("mul_min_x_min", r, 16384);
    beat(0, -128, 127, 1'b0, 1'b0, r, f);  check("mul_min_x_max", r, -16256);

    beat(0, 5, 6, 1'b1, 1'b1, r, f);   check("acc_clr_30", r, 30);
    beat(0, -4, 3, 1'b1, 1'b0, r, f);  check("acc_18", r, 18);
    beat(0, 2, 2, 1'b0, 1'b0, r, f);   check("prod_only_4", r, 4);
    beat(0, 1, 1, 1'b1, 1'b0, r, f);   check("acc_19", r, 19);
    beat(0, 2, 2, 1'b0, 1'b1, r, f);   check("clr_ignored_prod", r, 4);
    beat(0, 1, 1, 1'b1, 1'b0, r, f);   check("clr_ignored_acc", r, 20);
    check("acc_no_ovf", f, 0);

    beat(1, 127, 127, 1'b1, 1'b1, r, f); check("ovf_b1", r, 16129);  check("ovf_b1_flag", f, 0);
    beat(1, 127, 127, 1'b1, 1'b0, r, f); check("ovf_b2", r, 32258);  check("ovf_b2_flag", f, 0);
    beat(1, 127, 127, 1'b1, 1'b0, r, f); check("ovf_b3", r, -17149); check("ovf_b3_flag", f, 1);

    // Reset two cycles into CALC must take effect without a clock edge.
    @(posedge clk); #1;
    a_bus = 16'(9); b_bus = 16'(9); mode = 1'b0; clr = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("pre_rst_busy", ir[0], 0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", ov[0], 0);
    check("arst_in_ready",  ir[0], 1);
    check("arst_result",    pick(0), 0);
    check("arst_ovf_w8a16", fl[1], 0);
    check("arst_res_w8a16", pick(1), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(0, 3, 3, 1'b0, 1'b0, r, f);     check("post_rst_9", r, 9);
    beat(0, 1, 1, 1'b1, 1'b0, r, f);     check("post_rst_acc", r, 1);
    beat(1, 127, 127, 1'b1, 1'b0, r, f); check("post_rst_w8a16", r, 16129);
    beat(1, 1, 1, 1'b1, 1'b1, r, f);     check("clr_beat", r, 1); check("clr_beat_flag", f, 0);

    // Backpressure with a pending beat held on the input.
    ordy = 1'b0;
    beat(0, 3, 4, 1'b0, 1'b0, r, f);     check("bp_result", r, 12);
    a_bus = 16'(5); b_bus = 16'(5); iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", pick(0), 12);
      check("bp_in_ready", ir[0], 0);
      check("bp_out_valid", ov[0], 1);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", ov[0], 0);
    check("bp_release_ir", ir[0], 1);
    beat(0, 5, 5, 1'b0, 1'b0, r, f);     check("bp_pending", r, 25);

    // Exhaustive WIDTH=6 with wrapping accumulation.
    acc_m = 0; ovf_m = 1'b0;
    for (int a = -32; a < 32; a++) begin
      for (int b = -32; b < 32; b++) begin
        c  = (a == -32) && (b == -32);
        p  = longint'(a) * longint'(b);
        bs = c ? 0 : acc_m;
        s  = bs + p;
        exp   = wrap(s, 16);
        ovf_m = (c ? 1'b0 : ovf_m) | (s != exp);
        acc_m = exp;
        beat(2, a, b, 1'b1, c, r, f);
        check("w6_result", r, exp);
        check("w6_ovf", f, ovf_m);
      end
    end

    // Random WIDTH=16 with mixed modes and output stalls.
    acc_m = 0; ovf_m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      t16a = 16'($urandom);
      t16b = 16'($urandom);
      m = 1'($urandom);
      c = (i == 0) || ($urandom_range(0, 7) == 0);
      p = longint'(t16a) * longint'(t16b);
      if (m || i == 0) begin
        m  = 1'b1;
        bs = c ? 0 : acc_m;
        s  = bs + p;
        exp   = wrap(s, 36);
        ovf_m = (c ? 1'b0 : ovf_m) | (s != exp);
        acc_m = exp;
      end else begin
        exp = p;
      end
      beat(3, int'(t16a), int'(t16b), m, c, r, f);
      check("w16_result", r, exp);
      check("w16_ovf", f, ovf_m);
      k = $urandom_range(0, 3);
      if (k > 0) begin
        ordy = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        check("w16_stall_hold", pick(3), exp);
        check("w16_stall_ov", ov[3], 1);
        ordy = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
